factor_matrix_server: RTL and testbench

- Responder side of the compute-PE factor-row fetch interface.
- Accepts per-mode factor-matrix row address requests from NUM_COMPUTE_UNITS PEs and arbitrates them round-robin.
- Reads rows from on-chip per-mode factor banks and returns RANK-wide rows tagged with the requesting compute id, plus a one-hot data ack.
- Also provides a write port so the DMA loader can fill the factor banks.

---
 rtl/factor_server_pkg.sv | 30 +++
 rtl/factor_bank_ram.sv | 20 ++
 rtl/factor_matrix_server.sv | 147 ++++++++++++++
 tb/tb_factor_matrix_server.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/factor_server_pkg.sv
// Shared sizing, row/slot types and address helpers for the factor-matrix server.
// Top-level parameters default to these values and must stay in step with them.
package factor_server_pkg;

    localparam int DEF_TD    = 3;
    localparam int DEF_FMW   = 32;
    localparam int DEF_RANK  = 16;
    localparam int DEF_MTAW  = 16;
    localparam int DEF_DEPTH = 1024;
    localparam int DEF_NCU   = 8;

    localparam int NUM_MODES = DEF_TD - 1;
    localparam int DW        = $clog2(DEF_DEPTH);
    localparam int IDW       = $clog2(DEF_NCU) + 1;
    localparam int MODE_W    = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;

    typedef logic [DEF_RANK-1:0][DEF_FMW-1:0] factor_row_t;

    typedef struct packed {
        logic                                 pending;
        logic [NUM_MODES-1:0]                 mask;
        logic [NUM_MODES-1:0][DEF_MTAW-1:0]   addr;
    } req_slot_t;

    // Any bit above the bank index makes the request out of range.
    function automatic logic addr_oob(input logic [DEF_MTAW-1:0] a);
        return (a >> DW) != '0;
    endfunction

endpackage

// File: rtl/factor_bank_ram.sv
// One mode's factor bank: simple dual-port, registered read, read-first on collision.
module factor_bank_ram
    import factor_server_pkg::*;
(
    input  logic                               clk_i,
    input  logic                               wr_en_i,
    input  logic [DW-1:0]                      wr_addr_i,
    input  logic [DEF_RANK-1:0][DEF_FMW-1:0]   wr_data_i,
    input  logic [DW-1:0]                      rd_addr_i,
    output logic [DEF_RANK-1:0][DEF_FMW-1:0]   rd_data_o
);

    factor_row_t mem_q [DEF_DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
        rd_data_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/factor_matrix_server.sv
// Factor-row fetch responder: per-PE request slots, round-robin grant,
// per-mode bank read and a registered response with one-hot ack.
module factor_matrix_server
    import factor_server_pkg::*;
#(
    parameter int TENSOR_DIMENSIONS      = DEF_TD,
    parameter int FACTOR_MATRIX_WIDTH    = DEF_FMW,
    parameter int RANK_FACTOR_MATRIX     = DEF_RANK,
    parameter int MODE_TENSOR_ADDR_WIDTH = DEF_MTAW,
    parameter int FACTOR_DEPTH           = DEF_DEPTH,
    parameter int NUM_COMPUTE_UNITS      = DEF_NCU
) (
    input  logic                                                                    clk_i,
    input  logic                                                                    rst_i,
    input  logic [NUM_COMPUTE_UNITS-1:0][TENSOR_DIMENSIONS-2:0]                     pe_req_addr_en_i,
    input  logic [NUM_COMPUTE_UNITS-1:0][TENSOR_DIMENSIONS-2:0][MODE_TENSOR_ADDR_WIDTH-1:0] pe_req_addr_i,
    input  logic                                                                    wr_en_i,
    input  logic [MODE_W-1:0]                                                       wr_mode_i,
    input  logic [DW-1:0]                                                           wr_addr_i,
    input  logic [RANK_FACTOR_MATRIX-1:0][FACTOR_MATRIX_WIDTH-1:0]                  wr_data_i,
    output logic [TENSOR_DIMENSIONS-2:0]                                            resp_en_o,
    output logic [TENSOR_DIMENSIONS-2:0][RANK_FACTOR_MATRIX-1:0][FACTOR_MATRIX_WIDTH-1:0] resp_data_o,
    output logic [IDW-1:0]                                                          resp_compute_id_o,
    output logic [NUM_COMPUTE_UNITS-1:0]                                            factor_data_ack_o,
    output logic                                                                    req_overflow_err_o,
    output logic                                                                    addr_range_err_o
);

    localparam int NCU = NUM_COMPUTE_UNITS;
    localparam int PW  = IDW - 1;

    req_slot_t [NCU-1:0]              slot_q;
    logic [PW-1:0]                    ptr_q;
    logic                             gnt_vld;
    logic [PW-1:0]                    gnt_idx;
    logic [NCU-1:0]                   gnt_oh;
    logic [NCU-1:0]                   req_any;
    logic [NCU-1:0]                   pend_vec;
    logic [NUM_MODES-1:0]             gnt_oob;
    logic [NUM_MODES-1:0][DW-1:0]     rd_addr;
    factor_row_t [NUM_MODES-1:0]      rd_data;

    logic                             s1_vld_q;
    logic [PW-1:0]                    s1_id_q;
    logic [NUM_MODES-1:0]             s1_mask_q;
    logic [NUM_MODES-1:0]             s1_oob_q;

    logic                             ovf_err_q;
    logic                             rng_err_q;
    logic [NUM_MODES-1:0]             resp_en_q;
    factor_row_t [NUM_MODES-1:0]      resp_data_q;
    logic [IDW-1:0]                   resp_id_q;
    logic [NCU-1:0]                   ack_q;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NCU) s = s - NCU;
        return PW'(s);
    endfunction

    // Scan from the farthest offset down so the slot nearest the pointer wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = NCU - 1; i >= 0; i--) begin
            if (slot_q[wrap_add(ptr_q, unsigned'(i))].pending) begin
                gnt_vld = 1'b1;
                gnt_idx = wrap_add(ptr_q, unsigned'(i));
            end
        end
    end

    always_comb begin
        gnt_oh = gnt_vld ? (NCU'(1) << gnt_idx) : '0;
        for (int p = 0; p < NCU; p++) begin
            req_any[p]  = |pe_req_addr_en_i[p];
            pend_vec[p] = slot_q[p].pending;
        end
        for (int m = 0; m < NUM_MODES; m++) begin
            gnt_oob[m] = addr_oob(slot_q[gnt_idx].addr[m]);
            rd_addr[m] = slot_q[gnt_idx].addr[m][DW-1:0];
        end
    end

    for (genvar m = 0; m < NUM_MODES; m++) begin : g_bank
        factor_bank_ram u_bank (
            .clk_i     (clk_i),
            .wr_en_i   (wr_en_i && (wr_mode_i == MODE_W'(m))),
            .wr_addr_i (wr_addr_i),
            .wr_data_i (wr_data_i),
            .rd_addr_i (rd_addr[m]),
            .rd_data_o (rd_data[m])
        );
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            slot_q      <= '0;
            ptr_q       <= '0;
            s1_vld_q    <= 1'b0;
            s1_id_q     <= '0;
            s1_mask_q   <= '0;
            s1_oob_q    <= '0;
            ovf_err_q   <= 1'b0;
            rng_err_q   <= 1'b0;
            resp_en_q   <= '0;
            resp_data_q <= '0;
            resp_id_q   <= '0;
            ack_q       <= '0;
        end else begin
            // A slot granted this cycle is free to take the next request.
            for (int p = 0; p < NCU; p++) begin
                if (req_any[p] && !(pend_vec[p] && !gnt_oh[p])) begin
                    slot_q[p].pending <= 1'b1;
                    slot_q[p].mask    <= pe_req_addr_en_i[p];
                    slot_q[p].addr    <= pe_req_addr_i[p];
                end else if (gnt_oh[p]) begin
                    slot_q[p].pending <= 1'b0;
                end
            end
            if (|(req_any & pend_vec & ~gnt_oh)) ovf_err_q <= 1'b1;
            if (gnt_vld && |(slot_q[gnt_idx].mask & gnt_oob)) rng_err_q <= 1'b1;
            if (gnt_vld) ptr_q <= wrap_add(gnt_idx, 1);

            s1_vld_q  <= gnt_vld;
            s1_id_q   <= gnt_idx;
            s1_mask_q <= gnt_vld ? slot_q[gnt_idx].mask : '0;
            s1_oob_q  <= gnt_oob;

            resp_en_q <= s1_vld_q ? s1_mask_q : '0;
            resp_id_q <= s1_vld_q ? {1'b0, s1_id_q} : '0;
            ack_q     <= s1_vld_q ? (NCU'(1) << s1_id_q) : '0;
            for (int m = 0; m < NUM_MODES; m++) begin
                resp_data_q[m] <= (s1_vld_q && s1_mask_q[m] && !s1_oob_q[m]) ? rd_data[m] : '0;
            end
        end
    end

    assign resp_en_o          = resp_en_q;
    assign resp_data_o        = resp_data_q;
    assign resp_compute_id_o  = resp_id_q;
    assign factor_data_ack_o  = ack_q;
    assign req_overflow_err_o = ovf_err_q;
    assign addr_range_err_o   = rng_err_q;

endmodule

// File: tb/tb_factor_matrix_server.sv
// Directed bench for factor_matrix_server: a slot/queue model checked every cycle,
// plus literal expectations at the response cycles of each scenario.
module tb_factor_matrix_server;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [7:0][1:0]           pe_req_addr_en;
    logic [7:0][1:0][15:0]     pe_req_addr;
    logic                      wr_en;
    logic [0:0]                wr_mode;
    logic [9:0]                wr_addr;
    logic [15:0][31:0]         wr_data;
    logic [1:0]                resp_en;
    logic [1:0][15:0][31:0]    resp_data;
    logic [3:0]                resp_compute_id;
    logic [7:0]                factor_data_ack;
    logic                      req_overflow_err;
    logic                      addr_range_err;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;
    logic [511:0] R11, R22, RAA;

    factor_matrix_server dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .pe_req_addr_en_i   (pe_req_addr_en),
        .pe_req_addr_i      (pe_req_addr),
        .wr_en_i            (wr_en),
        .wr_mode_i          (wr_mode),
        .wr_addr_i          (wr_addr),
        .wr_data_i          (wr_data),
        .resp_en_o          (resp_en),
        .resp_data_o        (resp_data),
        .resp_compute_id_o  (resp_compute_id),
        .factor_data_ack_o  (factor_data_ack),
        .req_overflow_err_o (req_overflow_err),
        .addr_range_err_o   (addr_range_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // Model: pending requests per PE, a rotating pointer, and a two-deep delay
    // line from the grant decision to the visible response.
    logic [511:0] mem [2][1024];
    bit           m_pend [8];
    logic [1:0]   m_mask [8];
    logic [15:0]  m_addr [8][2];
    int           m_ptr;
    bit           m_ovf, m_rng;
    bit           st_v, out_v;
    logic [1:0]   st_en, out_en;
    int           st_id, out_id;
    logic [511:0] st_d [2];
    logic [511:0] out_d [2];
    logic [7:0]   exp_ack;

    always @(posedge clk) begin : mdl
        int g;
        logic [15:0] a;
        g = -1;
        if (!rst) begin
            for (int p = 0; p < 8; p++) m_pend[p] = 1'b0;
            m_ptr = 0; m_ovf = 0; m_rng = 0;
            st_v = 0; st_en = 0; st_id = 0; out_v = 0; out_en = 0; out_id = 0;
            for (int m = 0; m < 2; m++) begin st_d[m] = '0; out_d[m] = '0; end
        end else begin
            out_v = st_v; out_en = st_en; out_id = st_id;
            out_d[0] = st_d[0]; out_d[1] = st_d[1];
            for (int i = 0; i < 8; i++)
                if (g < 0 && m_pend[(m_ptr + i) % 8]) g = (m_ptr + i) % 8;
            st_v = (g >= 0); st_en = 0; st_id = 0; st_d[0] = '0; st_d[1] = '0;
            if (g >= 0) begin
                st_id = g; st_en = m_mask[g];
                for (int m = 0; m < 2; m++) begin
                    if (m_mask[g][m]) begin
                        a = m_addr[g][m];
                        if (a >= 16'd1024) m_rng = 1'b1;
                        else st_d[m] = mem[m][a[9:0]];
                    end
                end
                m_pend[g] = 1'b0;
                m_ptr = (g + 1) % 8;
            end
            for (int p = 0; p < 8; p++) begin
                if (pe_req_addr_en[p] != 2'b00) begin
                    if (m_pend[p]) m_ovf = 1'b1;
                    else begin
                        m_pend[p] = 1'b1;
                        m_mask[p] = pe_req_addr_en[p];
                        m_addr[p][0] = pe_req_addr[p][0];
                        m_addr[p][1] = pe_req_addr[p][1];
                    end
                end
            end
        end
        if (wr_en) mem[wr_mode][wr_addr] = wr_data;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            exp_ack = 8'd0;
            if (out_v) exp_ack[out_id] = 1'b1;
            chk("cyc_en",   512'(resp_en), 512'(out_en));
            chk("cyc_d0",   resp_data[0], out_d[0]);
            chk("cyc_d1",   resp_data[1], out_d[1]);
            chk("cyc_id",   512'(resp_compute_id), 512'(out_id));
            chk("cyc_ack",  512'(factor_data_ack), 512'(exp_ack));
            chk("cyc_errs", 512'({req_overflow_err, addr_range_err}), 512'({m_ovf, m_rng}));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic req(input int p, input logic [1:0] en, input logic [15:0] a0, input logic [15:0] a1);
        pe_req_addr_en[p] = en;
        pe_req_addr[p][0] = a0;
        pe_req_addr[p][1] = a1;
    endtask

    task automatic clr_req();
        pe_req_addr_en = '0;
        pe_req_addr    = '0;
    endtask

    task automatic wr(input logic [0:0] mode, input logic [9:0] addr, input logic [511:0] data);
        wr_en = 1'b1; wr_mode = mode; wr_addr = addr; wr_data = data;
        step(1);
        wr_en = 1'b0;
    endtask

    task automatic rst_pulse();
        rst = 1'b0;
        step(1);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        R11 = {16{32'h11111111}};
        R22 = {16{32'h22222222}};
        RAA = {16{32'hAAAAAAAA}};
        for (int m = 0; m < 2; m++)
            for (int r = 0; r < 1024; r++) mem[m][r] = '0;
        rst = 1'b0; wr_en = 1'b0; wr_mode = '0; wr_addr = '0; wr_data = '0;
        clr_req();
        step(2);
        chk_on = 1'b1;
        chk("rst_en",   512'(resp_en), 512'(0));
        chk("rst_ack",  512'(factor_data_ack), 512'(0));
        chk("rst_errs", 512'({req_overflow_err, addr_range_err}), 512'(0));
        rst = 1'b1;

        // 1: single two-mode request, three-cycle latency, one-cycle response
        wr(1'b0, 10'd5, R11);
        wr(1'b1, 10'd9, R22);
        req(2, 2'b11, 16'd5, 16'd9);
        step(1); clr_req(); step(2);
        chk("t1_en",  512'(resp_en), 512'(2'b11));
        chk("t1_d0",  resp_data[0], R11);
        chk("t1_d1",  resp_data[1], R22);
        chk("t1_id",  512'(resp_compute_id), 512'(2));
        chk("t1_ack", 512'(factor_data_ack), 512'(8'b0000_0100));
        step(1);
        chk("t1_once", 512'({resp_en, factor_data_ack}), 512'(0));

        // 2: round-robin order from pointer 0, then from pointer 1
        rst_pulse();
        req(0, 2'b01, 16'd5, 16'd0); req(3, 2'b10, 16'd0, 16'd9); req(7, 2'b01, 16'd5, 16'd0);
        step(1); clr_req(); step(2);
        chk("t2a_id0", 512'(resp_compute_id), 512'(0));
        step(1);
        chk("t2a_id3", 512'(resp_compute_id), 512'(3));
        chk("t2a_d1",  resp_data[1], R22);
        step(1);
        chk("t2a_id7", 512'(resp_compute_id), 512'(7));
        chk("t2a_ack", 512'(factor_data_ack), 512'(8'b1000_0000));
        req(0, 2'b01, 16'd5, 16'd0);
        step(1); clr_req(); step(4);
        req(0, 2'b01, 16'd5, 16'd0); req(3, 2'b10, 16'd0, 16'd9); req(7, 2'b01, 16'd5, 16'd0);
        step(1); clr_req(); step(2);
        chk("t2b_id3", 512'(resp_compute_id), 512'(3));
        step(1);
        chk("t2b_id7", 512'(resp_compute_id), 512'(7));
        step(1);
        chk("t2b_id0", 512'(resp_compute_id), 512'(0));

        // 3: second request on a still-pending slot is dropped
        rst_pulse();
        req(0, 2'b01, 16'd5, 16'd0); req(1, 2'b10, 16'd0, 16'd9);
        step(1); clr_req();
        req(1, 2'b01, 16'd5, 16'd0);
        step(1); clr_req(); step(1);
        chk("t3_id0", 512'(resp_compute_id), 512'(0));
        step(1);
        chk("t3_id1", 512'(resp_compute_id), 512'(1));
        chk("t3_en",  512'(resp_en), 512'(2'b10));
        chk("t3_d1",  resp_data[1], R22);
        chk("t3_d0",  resp_data[0], 512'(0));
        step(1);
        chk("t3_none", 512'(resp_en), 512'(0));
        chk("t3_ovf",  512'(req_overflow_err), 512'(1));
        step(3);
        chk("t3_sticky", 512'(req_overflow_err), 512'(1));

        // 4: out-of-range address returns zero data with resp_en set
        req(4, 2'b01, 16'h0400, 16'd0);
        step(1); clr_req(); step(2);
        chk("t4_en",  512'(resp_en), 512'(2'b01));
        chk("t4_d0",  resp_data[0], 512'(0));
        chk("t4_id",  512'(resp_compute_id), 512'(4));
        chk("t4_rng", 512'(addr_range_err), 512'(1));

        // 5: write in the grant cycle is read-first
        req(5, 2'b01, 16'd5, 16'd0);
        step(1); clr_req();
        wr_en = 1'b1; wr_mode = 1'b0; wr_addr = 10'd5; wr_data = RAA;
        step(1); wr_en = 1'b0; step(1);
        chk("t5_old", resp_data[0], R11);
        req(5, 2'b01, 16'd5, 16'd0);
        step(1); clr_req(); step(2);
        chk("t5_new", resp_data[0], RAA);

        // 6: reset with requests in flight drops them; banks keep contents
        req(0, 2'b01, 16'd5, 16'd0); req(1, 2'b10, 16'd0, 16'd9); req(2, 2'b01, 16'd5, 16'd0);
        step(1); clr_req(); step(1);
        rst = 1'b0; step(1); rst = 1'b1;
        chk("t6_en",   512'(resp_en), 512'(0));
        chk("t6_data", resp_data, 512'(0));
        chk("t6_errs", 512'({req_overflow_err, addr_range_err}), 512'(0));
        step(4);
        chk("t6_quiet", 512'({resp_en, factor_data_ack}), 512'(0));
        req(6, 2'b11, 16'd5, 16'd9);
        step(1); clr_req(); step(2);
        chk("t6_d0", resp_data[0], RAA);
        chk("t6_d1", resp_data[1], R22);
        chk("t6_id", 512'(resp_compute_id), 512'(6));

        step(3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
